// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : Initiator side of the data-memory interface. Accepts one load
//             or store at a time, produces a word address and byte strobe,
//             replicates store data across lanes and extracts/extends loads.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
   parameter int MEM_LATENCY = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic [3:0]  mem_write,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Counter value on which the memory read word is valid.
   localparam logic [1:0] LAT_LAST = MEM_LATENCY[1:0];

   logic [1:0]  state;
   logic [1:0]  addr_lo;
   logic [1:0]  size_q;
   logic        write_q;
   logic        unsigned_q;
   logic [1:0]  lat_cnt;

   logic        req_misaligned;
   logic [31:0] req_repl_data;
   logic [3:0]  strobe;
   logic [31:0] rd_shifted;
   logic [31:0] load_ext;

   // Alignment fault detection on the incoming request.
   always_comb begin
      req_misaligned = 1'b0;
      if (req_size == 2'b01)
         req_misaligned = req_addr[0];
      else if (req_size[1])
         req_misaligned = (req_addr[1:0] != 2'b00);
   end

   // Replicate right-aligned store data into every lane it may land in.
   always_comb begin
      case (req_size)
         2'b00:   req_repl_data = {4{req_wdata[7:0]}};
         2'b01:   req_repl_data = {2{req_wdata[15:0]}};
         default: req_repl_data = req_wdata;
      endcase
   end

   // Byte-enable strobe from the latched size and byte offset.
   always_comb begin
      case (size_q)
         2'b00:   strobe = 4'b0001 << addr_lo;
         2'b01:   strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: strobe = 4'b1111;
      endcase
   end

   // Move the addressed byte/halfword to bit 0 and extend it.
   always_comb begin
      rd_shifted = mem_read_data >> {addr_lo, 3'b000};
      case (size_q)
         2'b00:   load_ext = unsigned_q ? {24'h0, rd_shifted[7:0]}
                                        : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
         2'b01:   load_ext = unsigned_q ? {16'h0, rd_shifted[15:0]}
                                        : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
         default: load_ext = mem_read_data;
      endcase
   end

   // Handshake and memory strobes; reset suppresses any access in its cycle.
   always_comb begin
      req_ready  = (state == ST_IDLE);
      resp_valid = (state == ST_RESP);
      mem_read   = (state == ST_ACCESS) && !write_q && !reset;
      mem_write  = ((state == ST_ACCESS) && write_q && !reset) ? strobe : 4'b0000;
   end

   // Request latch, access sequencing and response capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         addr_lo         <= 2'b00;
         size_q          <= 2'b00;
         write_q         <= 1'b0;
         unsigned_q      <= 1'b0;
         lat_cnt         <= 2'b00;
         resp_rdata      <= 32'h0;
         resp_misaligned <= 1'b0;
         mem_address     <= 32'h0;
         mem_write_data  <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  mem_address    <= {2'b00, req_addr[31:2]};
                  addr_lo        <= req_addr[1:0];
                  size_q         <= req_size;
                  write_q        <= req_write;
                  unsigned_q     <= req_unsigned;
                  mem_write_data <= req_repl_data;
                  lat_cnt        <= 2'b00;
                  resp_rdata     <= 32'h0;
                  if (req_misaligned) begin
                     resp_misaligned <= 1'b1;
                     state           <= ST_RESP;
                  end else begin
                     resp_misaligned <= 1'b0;
                     state           <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (write_q) begin
                  state <= ST_RESP;
               end else if (lat_cnt == LAT_LAST) begin
                  resp_rdata <= load_ext;
                  state      <= ST_RESP;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            ST_RESP: begin
               if (resp_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : Self-checking bench for load_store_unit with a byte-array
//             reference model and a word-addressed memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic [31:0] mem_address;
   logic        mem_read;
   logic [3:0]  mem_write;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic        mem_init = 1'b1;
   logic [31:0] mem [16];
   logic [7:0]  ref_mem [64];

   int n_cmp = 0;
   int n_err = 0;

   load_store_unit #(.MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_misaligned(resp_misaligned),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int w);
      logic [31:0] x;
      x = 32'h9E3779B9 * (w + 1);
      return x ^ 32'h5A5A1234;
   endfunction

   // Word memory: read data stays valid while the address is held.
   assign mem_read_data = mem[mem_address[3:0]];

   // Memory model: preload, then byte-lane writes from the strobe.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int w = 0; w < 16; w++) mem[w] <= init_word(w);
      end else begin
         for (int k = 0; k < 4; k++)
            if (mem_write[k]) mem[mem_address[3:0]][8*k +: 8] <= mem_write_data[8*k +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un, input int idx);
      logic [31:0] v;
      case (sz)
         2'd0:    v = un ? {24'h0, ref_mem[idx]} : {{24{ref_mem[idx][7]}}, ref_mem[idx]};
         2'd1:    v = un ? {16'h0, ref_mem[idx+1], ref_mem[idx]}
                         : {{16{ref_mem[idx+1][7]}}, ref_mem[idx+1], ref_mem[idx]};
         default: v = {ref_mem[idx+3], ref_mem[idx+2], ref_mem[idx+1], ref_mem[idx]};
      endcase
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_rdata"}, resp_rdata, 0);
      chk({tag, "_resp_mis"}, resp_misaligned, 0);
      chk({tag, "_mem_read"}, mem_read, 0);
      chk({tag, "_mem_write"}, mem_write, 0);
      chk({tag, "_mem_addr"}, mem_address, 0);
      chk({tag, "_mem_wdata"}, mem_write_data, 0);
   endtask

   // One complete transaction; called at #1 after an edge with the DUT idle.
   task automatic run_req(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
      int          idx, cyc, nrd, nwr, addr_bad, both;
      logic        mis;
      logic [31:0] exp_rd, exp_data, got_data, held;
      logic [3:0]  exp_strb, got_strb;
      idx = int'(a & 32'd63);
      mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
      exp_rd = (mis || wr) ? 32'h0 : ref_load(sz, un, idx);
      case (sz)
         2'd0:    begin exp_strb = 4'b0001 << a[1:0]; exp_data = {4{wd[7:0]}}; end
         2'd1:    begin exp_strb = a[1] ? 4'b1100 : 4'b0011; exp_data = {2{wd[15:0]}}; end
         default: begin exp_strb = 4'b1111; exp_data = wd; end
      endcase

      chk("idle_ready", req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
      req_addr = a; req_wdata = wd; resp_ready = (hold == 0);
      step();
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      cyc = 1; nrd = 0; nwr = 0; addr_bad = 0; both = 0;
      got_strb = 4'h0; got_data = 32'h0;
      while (!resp_valid && cyc < 20) begin
         if (mem_read || mem_write != 4'h0)
            if (mem_address !== (a >> 2)) addr_bad++;
         if (mem_read && mem_write != 4'h0) both++;
         if (mem_read) nrd++;
         if (mem_write != 4'h0) begin
            nwr++; got_strb = mem_write; got_data = mem_write_data;
         end
         step();
         cyc++;
      end
      chk("latency", cyc, mis ? 1 : (wr ? 2 : 2 + LAT));
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_mis", resp_misaligned, mis);
      chk("addr_held", addr_bad, 0);
      chk("rd_wr_excl", both, 0);
      chk("read_cycles", nrd, (mis || wr) ? 0 : LAT + 1);
      chk("write_cycles", nwr, (!mis && wr) ? 1 : 0);
      if (!mis && wr) begin
         chk("strobe", got_strb, exp_strb);
         chk("wdata", got_data, exp_data);
         for (int k = 0; k < 4; k++)
            if (exp_strb[k]) ref_mem[(idx & 60) + k] = exp_data[8*k +: 8];
      end
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_write = $urandom; req_addr = $urandom;
         chk("resp_ready_low", req_ready, 0);
         step();
         chk("hold_valid", resp_valid, 1);
         chk("hold_rdata", resp_rdata, held);
         chk("hold_mis", resp_misaligned, mis);
         chk("hold_no_mem", {mem_read, mem_write}, 0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      step();
      chk("resp_done", resp_valid, 0);
      chk("back_idle", req_ready, 1);
   endtask

   // Abort an access with reset in its first ACCESS cycle.
   task automatic reset_mid(input logic wr, input logic [31:0] a);
      req_valid = 1'b1; req_write = wr; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = a; req_wdata = $urandom;
      step();
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_cycle_no_mem", {mem_read, mem_write}, 0);
      step();
      check_reset_outputs("rst_mid");
      reset = 1'b0;
      step();
      chk("rst_no_resp", resp_valid, 0);
   endtask

   initial begin
      for (int w = 0; w < 16; w++)
         for (int k = 0; k < 4; k++) ref_mem[4*w + k] = init_word(w) >> (8*k);

      step(); step();
      check_reset_outputs("reset");
      reset = 1'b0;
      mem_init = 1'b0;
      step();

      // Directed cases
      run_req(1, 2'd2, 0, 32'h0000_0104, 32'hDEADBEEF, 0);
      run_req(1, 2'd0, 0, 32'h0000_0003, 32'h0000_00A5, 0);
      run_req(1, 2'd1, 0, 32'h0000_0002, 32'h0000_1234, 0);
      run_req(1, 2'd2, 0, 32'h0000_0000, 32'h80FF_7F01, 0);
      run_req(0, 2'd0, 0, 32'h0000_0003, 32'h0, 0);
      chk("lb_value", resp_rdata, 32'hFFFF_FF80);
      run_req(0, 2'd0, 1, 32'h0000_0003, 32'h0, 0);
      chk("lbu_value", resp_rdata, 32'h0000_0080);
      run_req(0, 2'd1, 0, 32'h0000_0002, 32'h0, 0);
      chk("lh_value", resp_rdata, 32'hFFFF_80FF);
      run_req(0, 2'd1, 1, 32'h0000_0000, 32'h0, 0);
      chk("lhu_value", resp_rdata, 32'h0000_7F01);
      run_req(0, 2'd2, 0, 32'h0000_0006, 32'h0, 0);
      run_req(0, 2'd1, 0, 32'h0000_0001, 32'h0, 0);
      run_req(1, 2'd3, 0, 32'h0000_0009, 32'h1111_2222, 2);
      run_req(0, 2'd3, 0, 32'h0000_0004, 32'h0, 5);

      // Randomized traffic
      for (int t = 0; t < 60; t++)
         run_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3));

      // Reset during a load, then a normal store
      reset_mid(0, 32'h0000_0010);
      run_req(1, 2'd2, 0, 32'h0000_0014, 32'hCAFE_F00D, 0);
      run_req(0, 2'd2, 0, 32'h0000_0014, 32'h0, 0);

      // Reset during a store: memory must be untouched
      reset_mid(1, 32'h0000_0020);
      run_req(0, 2'd2, 0, 32'h0000_0020, 32'h0, 0);

      // Reset and request together: reset wins
      reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
      req_addr = 32'h0000_0024; req_wdata = 32'h0BAD_0BAD;
      step();
      reset = 1'b0; req_valid = 1'b0;
      chk("rst_wins_ready", req_ready, 1);
      step();
      chk("rst_wins_no_write", mem_write, 0);
      chk("rst_wins_no_resp", resp_valid, 0);
      run_req(0, 2'd2, 0, 32'h0000_0024, 32'h0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
